// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demux sequencers and the demux stages they drive.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        FILL = 1'b1
    } tdm_state_t;

    localparam int TDM_WIDTH = 8;
    localparam int TDM_NCH   = 8;

    // One bit of a slot-to-one-hot decode; callers loop k over the channels.
    function automatic logic slot_hot(input int slot, input int k);
        return slot == k;
    endfunction

endpackage

// File: rtl/tdm_out_bank.sv
// Output frame register with valid/ready handshake; a frame that arrives while the
// previous one is still unaccepted is dropped and flagged with a one-cycle ovf pulse.
module tdm_out_bank
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int NCH   = TDM_NCH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [NCH*WIDTH-1:0] frame,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 ovf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (load) begin
                // Accepting the old frame in the same cycle frees the bank for the new one.
                if (!out_valid || out_ready) begin
                    out_data  <= frame;
                    out_valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tdm_demux_seq.sv
// TDM demux sequencer: steers a framed serial sample stream into per-channel shadow
// registers and publishes each completed frame through tdm_out_bank.
//
// state | meaning
// HUNT  | waiting for a start-of-frame sample; other samples are ignored
// FILL  | collecting samples into shadow[slot] until slot NCH-1 is written
module tdm_demux_seq
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int NCH   = TDM_NCH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [WIDTH-1:0]     in_data,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH-1:0]       slot_we,
    output logic                 err_short,
    output logic                 err_ovf
);

    localparam int SW = $clog2(NCH);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);

    tdm_state_t           state;
    logic [SW-1:0]        slot;
    logic [WIDTH-1:0]     shadow [NCH];

    logic                 wr_en;
    logic [SW-1:0]        wr_slot;
    logic [NCH-1:0]       wr_onehot;
    logic                 load;
    logic [NCH*WIDTH-1:0] frame;

    always_comb begin
        wr_en   = 1'b0;
        wr_slot = '0;
        load    = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                wr_en = 1'b1;
            end else if (state == FILL) begin
                wr_en   = 1'b1;
                wr_slot = slot;
                load    = (slot == LAST_SLOT);
            end
        end
    end

    always_comb begin
        wr_onehot = '0;
        for (int k = 0; k < NCH; k++) begin
            wr_onehot[k] = slot_hot(int'(wr_slot), k);
        end
    end

    // The last sample goes straight from in_data into the published frame.
    always_comb begin
        frame = '0;
        for (int k = 0; k < NCH - 1; k++) begin
            frame[k*WIDTH +: WIDTH] = shadow[k];
        end
        frame[(NCH-1)*WIDTH +: WIDTH] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            slot      <= '0;
            slot_we   <= '0;
            err_short <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            slot_we   <= wr_en ? wr_onehot : '0;
            err_short <= in_valid && in_sof && (state == FILL);
            if (wr_en) begin
                shadow[wr_slot] <= in_data;
            end
            case (state)
                HUNT: begin
                    if (in_valid && in_sof) begin
                        slot  <= SW'(1);
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            slot <= SW'(1);
                        end else if (slot == LAST_SLOT) begin
                            slot  <= '0;
                            state <= HUNT;
                        end else begin
                            slot <= slot + SW'(1);
                        end
                    end
                end
                default: begin
                    slot  <= '0;
                    state <= HUNT;
                end
            endcase
        end
    end

    tdm_out_bank #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) u_out_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .frame     (frame),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .ovf       (err_ovf)
    );

endmodule

// File: tb/tb_tdm_demux_seq.sv
// Scoreboard bench for tdm_demux_seq: a frame-list reference model predicts published
// frames, slot strobes and error pulses; a negedge monitor compares against the DUT.
module tb_tdm_demux_seq;

    localparam int W = 8;
    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_sof;
    logic [W-1:0]   in_data;
    logic [N*W-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   slot_we;
    logic           err_short;
    logic           err_ovf;

    tdm_demux_seq #(.WIDTH(W), .NCH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot_we   (slot_we),
        .err_short (err_short),
        .err_ovf   (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: samples collected so far in the open frame, and the
    // consumer-side view of whether a published frame is still waiting.
    logic [W-1:0]   part[$];
    bit             in_frame;
    bit             pend;
    logic [N*W-1:0] frame_q[$];
    logic [N-1:0]   exp_we;
    bit             exp_short;
    bit             exp_ovf;

    logic           prev_v;
    logic [N*W-1:0] prev_d;

    function automatic void check(string name, logic [N*W-1:0] act, logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        part.delete();
        frame_q.delete();
        in_frame  = 0;
        pend      = 0;
        exp_we    = '0;
        exp_short = 0;
        exp_ovf   = 0;
    endfunction

    // Called once per rising edge with the inputs the DUT just sampled.
    function automatic void model_step();
        bit             complete;
        logic [N*W-1:0] f;
        complete  = 0;
        f         = '0;
        exp_we    = '0;
        exp_short = 0;
        exp_ovf   = 0;
        if (!rst_n) return;
        if (in_valid) begin
            if (in_sof) begin
                if (in_frame) exp_short = 1;
                part.delete();
                part.push_back(in_data);
                in_frame = 1;
                exp_we   = N'(1);
            end else if (in_frame) begin
                exp_we = N'(1) << part.size();
                part.push_back(in_data);
                if (part.size() == N) begin
                    for (int i = 0; i < N; i++) f[i*W +: W] = part[i];
                    complete = 1;
                    in_frame = 0;
                    part.delete();
                end
            end
        end
        if (complete) begin
            if (!pend || out_ready) begin
                frame_q.push_back(f);
                pend = 1;
            end else begin
                exp_ovf = 1;
            end
        end else if (pend && out_ready) begin
            pend = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            prev_d = '0;
        end else begin
            check("out_valid", N*W'(out_valid), N*W'(pend));
            check("slot_we", N*W'(slot_we), N*W'(exp_we));
            check("err_short", N*W'(err_short), N*W'(exp_short));
            check("err_ovf", N*W'(err_ovf), N*W'(exp_ovf));
            if (out_valid && (!prev_v || out_data !== prev_d)) begin
                if (frame_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_unexpected actual=%h expected=none at %0t", out_data, $time);
                end else begin
                    check("out_data", out_data, frame_q.pop_front());
                end
            end
            prev_v = out_valid;
            prev_d = out_data;
        end
    end

    task automatic drive(input bit v, input bit sof, input logic [W-1:0] d, input bit rdy);
        @(negedge clk);
        #2;
        in_valid  = v;
        in_sof    = sof;
        in_data   = d;
        out_ready = rdy;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), W'($urandom), rdy);
    endtask

    task automatic send_frame(input logic [W-1:0] base, input int gap, input bit rdy, input bit rdy_last);
        for (int i = 0; i < N; i++) begin
            drive(1'b1, i == 0, base + W'(i), (i == N - 1) ? rdy_last : rdy);
            if (i < N - 1) idle(gap, rdy);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_data", out_data, '0);
        check("rst_out_valid", N*W'(out_valid), '0);
        check("rst_slot_we", N*W'(slot_we), '0);
        check("rst_errs", N*W'({err_short, err_ovf}), '0);
        @(negedge clk);
        #3 rst_n = 1'b1;

        // nominal back-to-back frame
        send_frame(8'h10, 0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // samples before any SOF are ignored
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, W'($urandom), 1'b1);
        send_frame(8'hA0, 0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // short frame interrupted by a new SOF
        drive(1'b1, 1'b1, 8'h01, 1'b1);
        drive(1'b1, 1'b0, 8'h02, 1'b1);
        drive(1'b1, 1'b0, 8'h03, 1'b1);
        send_frame(8'hB0, 0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // gapped input
        send_frame(8'hC0, 2, 1'b1, 1'b1);
        idle(2, 1'b1);

        // back-pressure, overflow, then accept coincident with completion
        send_frame(8'h00, 0, 1'b0, 1'b0);
        send_frame(8'h20, 0, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        send_frame(8'h40, 0, 1'b0, 1'b0);
        send_frame(8'h60, 0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // async reset mid-frame with a frame still pending
        send_frame(8'h80, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 8'h90 + W'(i), 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_out_valid", N*W'(out_valid), '0);
        check("async_rst_slot_we", N*W'(slot_we), '0);
        check("async_rst_errs", N*W'({err_short, err_ovf}), '0);
        idle(2, 1'b0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        send_frame(8'hE0, 0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, W'($urandom),
                  $urandom_range(0, 2) != 0);
        end

        idle(4, 1'b1);
        check("frames_left", N*W'(frame_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
